// File: rtl/seq_detect_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_multi_if
// Brief    : Stream, configuration and status bundle for seq_detect_multi.
//            cfg_mask exists only when SEQ_DETECT_MASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_multi_if #(
  parameter int N  = 8,
  parameter int P  = 4,
  parameter int CW = 8
);
  localparam int c_iw = (P > 1) ? $clog2(P) : 1;
  localparam int c_lw = $clog2(N + 1);

  logic            a;
  logic            a_valid;
  logic            overlap;
  logic            cfg_we;
  logic [c_iw-1:0] cfg_idx;
  logic [N-1:0]    cfg_seq;
  logic [c_lw-1:0] cfg_len;
  logic            cfg_en;
`ifdef SEQ_DETECT_MASK_EN
  logic [N-1:0]    cfg_mask;
`endif
  logic            clr_cnt;
  logic            match;
  logic [P-1:0]    match_vec;
  logic [c_iw-1:0] match_idx;
  logic [CW-1:0]   match_cnt;
  logic            cnt_sat;

  modport master (
`ifdef SEQ_DETECT_MASK_EN
    output cfg_mask,
`endif
    output a, a_valid, overlap, cfg_we, cfg_idx, cfg_seq, cfg_len, cfg_en, clr_cnt,
    input  match, match_vec, match_idx, match_cnt, cnt_sat
  );

  modport slave (
`ifdef SEQ_DETECT_MASK_EN
    input  cfg_mask,
`endif
    input  a, a_valid, overlap, cfg_we, cfg_idx, cfg_seq, cfg_len, cfg_en, clr_cnt,
    output match, match_vec, match_idx, match_cnt, cnt_sat
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_multi
// Brief    : Serial detector matching an N-bit history against P programmable
//            pattern slots. Per-slot don't-care masks under SEQ_DETECT_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_multi #(
  parameter int N  = 8,
  parameter int P  = 4,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_detect_multi_if.slave bus
);
  localparam int              c_iw      = (P > 1) ? $clog2(P) : 1;
  localparam int              c_lw      = $clog2(N + 1);
  localparam logic [c_lw-1:0] c_len_max = c_lw'(N);

  logic [N-1:0]    r_hist;
  logic [c_lw-1:0] r_fill;
  logic [P-1:0]    r_match_vec;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    w_hist_nxt;
  logic [c_lw-1:0] w_fill_nxt;
  logic [P-1:0]    w_hits;
  logic [c_iw-1:0] w_idx;

  // Hits are judged on the history as it will look after this edge
  assign w_hist_nxt = bus.a_valid ? {r_hist[N-2:0], bus.a} : r_hist;
  assign w_fill_nxt = (bus.a_valid && (r_fill != c_len_max)) ? r_fill + c_lw'(1) : r_fill;

  for (genvar k = 0; k < P; k++) begin : g_slot
    logic [N-1:0]    r_seq;
    logic [c_lw-1:0] r_len;
    logic            r_en;
    logic [N-1:0]    w_care;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_seq <= '0;
        r_len <= c_len_max;
        r_en  <= 1'b0;
      end else if (bus.cfg_we && (bus.cfg_idx == c_iw'(k))) begin
        r_seq <= bus.cfg_seq;
        r_len <= (bus.cfg_len > c_len_max) ? c_len_max : bus.cfg_len;
        r_en  <= bus.cfg_en;
      end
    end

`ifdef SEQ_DETECT_MASK_EN
    logic [N-1:0] r_mask;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mask <= '0;
      end else if (bus.cfg_we && (bus.cfg_idx == c_iw'(k))) begin
        r_mask <= bus.cfg_mask;
      end
    end

    assign w_care = ~({N{1'b1}} << r_len) & ~r_mask;
`else
    assign w_care = ~({N{1'b1}} << r_len);
`endif

    assign w_hits[k] = bus.a_valid && r_en && (r_len != '0) && (w_fill_nxt >= r_len) &&
                       (((w_hist_nxt ^ r_seq) & w_care) == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_match_vec <= '0;
      r_cnt       <= '0;
    end else begin
      r_hist      <= w_hist_nxt;
      // Non-overlapping mode restarts the fill so every slot needs fresh bits
      r_fill      <= (!bus.overlap && (|w_hits)) ? '0 : w_fill_nxt;
      r_match_vec <= w_hits;
      if (bus.clr_cnt) begin
        r_cnt <= '0;
      end else if ((|w_hits) && !(&r_cnt)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_idx = '0;
    for (int i = P - 1; i >= 0; i--) begin
      if (r_match_vec[i]) begin
        w_idx = c_iw'(i);
      end
    end
  end

  assign bus.match     = |r_match_vec;
  assign bus.match_vec = r_match_vec;
  assign bus.match_idx = w_idx;
  assign bus.match_cnt = r_cnt;
  assign bus.cnt_sat   = &r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_seq_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_multi
// Brief    : Self-checking bench for seq_detect_multi (CW=8 and CW=2 copies
//            share one stimulus stream) against a bit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_multi;
  localparam int N    = 8;
  localparam int P    = 4;
  localparam int CW   = 8;
  localparam int CWS  = 2;
  localparam int c_iw = 2;
  localparam int c_lw = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_multi_if #(.N(N), .P(P), .CW(CW))  bus ();
  seq_detect_multi_if #(.N(N), .P(P), .CW(CWS)) bus_s ();

  seq_detect_multi #(.N(N), .P(P), .CW(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  seq_detect_multi #(.N(N), .P(P), .CW(CWS)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s.slave)
  );

  assign bus_s.a       = bus.a;
  assign bus_s.a_valid = bus.a_valid;
  assign bus_s.overlap = bus.overlap;
  assign bus_s.cfg_we  = bus.cfg_we;
  assign bus_s.cfg_idx = bus.cfg_idx;
  assign bus_s.cfg_seq = bus.cfg_seq;
  assign bus_s.cfg_len = bus.cfg_len;
  assign bus_s.cfg_en  = bus.cfg_en;
  assign bus_s.clr_cnt = bus.clr_cnt;
`ifdef SEQ_DETECT_MASK_EN
  assign bus_s.cfg_mask = bus.cfg_mask;
  initial bus.cfg_mask = '0;
`endif

  // Reference model: list of accepted bits, bits since last restart, slot table
  bit           m_bits[$];
  int           m_fresh;
  int           m_cnt;
  logic [N-1:0] m_seq[P];
  int           m_len[P];
  bit           m_en[P];
  logic [P-1:0] m_vec;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic model_reset();
    m_bits.delete();
    m_fresh = 0;
    m_cnt   = 0;
    m_vec   = '0;
    for (int k = 0; k < P; k++) begin
      m_seq[k] = '0;
      m_len[k] = N;
      m_en[k]  = 1'b0;
    end
  endtask

  task automatic model_edge(input bit av, input bit vv, input bit ovl, input bit clr,
                            input bit we, input int idx, input logic [N-1:0] seq,
                            input int len, input bit en);
    logic [P-1:0] hits;
    hits = '0;
    if (vv) begin
      m_bits.push_back(av);
      if (m_bits.size() > 64) void'(m_bits.pop_front());
      m_fresh++;
    end
    for (int k = 0; k < P; k++) begin
      if (vv && m_en[k] && m_len[k] > 0 && m_fresh >= m_len[k]) begin
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < m_len[k]; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_seq[k][i]) ok = 1'b0;
        hits[k] = ok;
      end
    end
    if (hits != 0 && !ovl) m_fresh = 0;
    if (clr) m_cnt = 0;
    else if (hits != 0) m_cnt++;
    if (we && idx < P) begin
      m_seq[idx] = seq;
      m_len[idx] = (len > N) ? N : len;
      m_en[idx]  = en;
    end
    m_vec = hits;
  endtask

  function automatic logic [31:0] exp_word();
    int idx;
    int c8;
    int c2;
    idx = 0;
    for (int i = P - 1; i >= 0; i--) if (m_vec[i]) idx = i;
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    return {13'd0, (m_vec != 0), m_vec, 2'(idx), 8'(c8), (c8 == 255), 2'(c2), (c2 == 3)};
  endfunction

  function automatic logic [31:0] act_word();
    return {13'd0, bus.match, bus.match_vec, bus.match_idx, bus.match_cnt, bus.cnt_sat,
            bus_s.match_cnt, bus_s.cnt_sat};
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle
  task automatic drive(input bit av, input bit vv, input bit clr = 1'b0, input bit we = 1'b0,
                       input int idx = 0, input logic [N-1:0] seq = '0, input int len = 0,
                       input bit en = 1'b0);
    bus.a       = av;
    bus.a_valid = vv;
    bus.clr_cnt = clr;
    bus.cfg_we  = we;
    bus.cfg_idx = c_iw'(idx);
    bus.cfg_seq = seq;
    bus.cfg_len = c_lw'(len);
    bus.cfg_en  = en;
    @(posedge clk);
    model_edge(av, vv, bus.overlap, clr, we, idx, seq, len, en);
    #1;
    bus.cfg_we  = 1'b0;
    bus.clr_cnt = 1'b0;
    bus.a_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act_word() !== exp_word())
      $display("FAIL reset_state: got %h want %h", act_word(), exp_word());
    if (act_word() !== exp_word()) n_bad++;
    reset_n = 1'b1;
    bus.overlap = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 0, 8'h01, 1, 1'b1);
    drive(1, 1);
    n_cmp++;
    if (act_word() !== exp_word() || bus.match !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_prehit: got %h want %h", act_word(), exp_word());
    end
    reset_n = 1'b0;
    #2;
    model_reset();
    n_cmp++;
    if (act_word() !== exp_word()) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", act_word(), exp_word());
    end
    reset_n = 1'b1;
    #1;
  endtask

  // Slot0 = 2D/6, optional slot1 = 101/3, stream 101101101 with optional idle gaps
  task automatic test_stream(input string name, input bit ovl, input bit two,
                             input int maxgap, input int exp_cnt);
    logic [8:0] s;
    int gap;
    s = 9'b101101101;
    apply_reset();
    bus.overlap = ovl;
    drive(0, 0, 1'b0, 1'b1, 0, 8'h2D, 6, 1'b1);
    if (two) drive(0, 0, 1'b0, 1'b1, 1, 8'h05, 3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
      repeat (gap) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
        n_cmp++;
        if (act_word() !== exp_word()) begin
          n_bad++;
          $display("FAIL %s_idle%0d: got %h want %h", name, i, act_word(), exp_word());
        end
      end
      drive(s[8 - i], 1'b1);
      n_cmp++;
      if (act_word() !== exp_word()) begin
        n_bad++;
        $display("FAIL %s_bit%0d: got %h want %h", name, i + 1, act_word(), exp_word());
      end
    end
    drive(0, 0);
    n_cmp++;
    if (bus.match_cnt !== CW'(exp_cnt) || bus.match !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_count: got cnt=%0d match=%b want cnt=%0d match=0",
               name, bus.match_cnt, bus.match, exp_cnt);
    end
  endtask

  task automatic test_fill_guard();
    apply_reset();
    bus.overlap = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 0, 8'h00, 8, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1);
      n_cmp++;
      if (act_word() !== exp_word() || bus.match !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_guard_bit%0d: got %h want %h", i + 1, act_word(), exp_word());
      end
    end
    drive(0, 1, 1'b0, 1'b1, 0, 8'hFF, 8, 1'b1);
    n_cmp++;
    if (act_word() !== exp_word() || bus.match_vec !== 4'b0001) begin
      n_bad++;
      $display("FAIL fill_guard_bit8: got %h want %h", act_word(), exp_word());
    end
    drive(0, 1);
    n_cmp++;
    if (act_word() !== exp_word() || bus.match !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_guard_newcfg: got %h want %h", act_word(), exp_word());
    end
  endtask

  task automatic test_saturation();
    logic [8:0] s;
    s = 9'b101010101;
    apply_reset();
    bus.overlap = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1, 8'h05, 3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive(s[8 - i], 1'b1);
      n_cmp++;
      if (act_word() !== exp_word()) begin
        n_bad++;
        $display("FAIL sat_bit%0d: got %h want %h", i + 1, act_word(), exp_word());
      end
    end
    n_cmp++;
    if (bus_s.match_cnt !== 2'd3 || bus_s.cnt_sat !== 1'b1 || bus.match_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL sat_hold: got cnt2=%0d sat=%b cnt8=%0d want 3 1 4",
               bus_s.match_cnt, bus_s.cnt_sat, bus.match_cnt);
    end
    drive(0, 1);
    drive(1, 1, 1'b1);
    n_cmp++;
    if (act_word() !== exp_word() || bus.match_cnt !== 8'd0 || bus.match_vec !== 4'b0010) begin
      n_bad++;
      $display("FAIL sat_clr_hit: got %h want %h", act_word(), exp_word());
    end
    drive(1, 1);
    reset_n = 1'b0;
    #2;
    model_reset();
    n_cmp++;
    if (act_word() !== exp_word()) begin
      n_bad++;
      $display("FAIL sat_midreset: got %h want %h", act_word(), exp_word());
    end
    reset_n = 1'b1;
    #1;
    drive(0, 1);
    drive(1, 1);
    n_cmp++;
    if (act_word() !== exp_word() || bus.match !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_after_reset: got %h want %h", act_word(), exp_word());
    end
  endtask

  task automatic test_random();
    int len;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) bus.overlap = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, P - 1)), N'($urandom),
            len, ($urandom_range(0, 3) != 0));
      n_cmp++;
      if (act_word() !== exp_word()) begin
        n_bad++;
        $display("FAIL random_c%0d: got %h want %h", c, act_word(), exp_word());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a       = 1'b0;
    bus.a_valid = 1'b0;
    bus.overlap = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_seq = '0;
    bus.cfg_len = '0;
    bus.cfg_en  = 1'b0;
    bus.clr_cnt = 1'b0;
    model_reset();
    test_reset();
    test_stream("overlap", 1'b1, 1'b0, 0, 2);
    test_stream("nonoverlap", 1'b0, 1'b0, 0, 1);
    test_stream("two_slots", 1'b1, 1'b1, 0, 3);
    test_stream("idle_gaps", 1'b1, 1'b0, 3, 2);
    test_fill_guard();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
